// File: rtl/mul_div_pkg.sv
// Shared types for the iterative RV32M multiply/divide unit: op encodings,
// FSM states and the iteration counter width.
package mul_div_pkg;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int unsigned DEF_DATA_WIDTH = 32;
    localparam int unsigned CNT_WIDTH      = $clog2(DEF_DATA_WIDTH) + 1;

endpackage

// File: rtl/mul_div_datapath.sv
// Unsigned magnitude datapath: one shift-add multiply step and one restoring
// divide step per enabled cycle, both running in parallel on the same operands.
module mul_div_datapath #(
    parameter int unsigned W = 32
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           load_i,
    input  logic           step_i,
    input  logic [W-1:0]   mag_a_i,
    input  logic [W-1:0]   mag_b_i,
    output logic [2*W-1:0] prod_nxt_o,
    output logic [W-1:0]   quot_nxt_o,
    output logic [W-1:0]   rem_nxt_o
);

    logic [2*W-1:0] acc_q, acc_d, mcand_q, mcand_d;
    logic [W-1:0]   mplier_q, mplier_d;
    logic [W-1:0]   rem_q, rem_d, quot_q, quot_d, dvsr_q, dvsr_d;
    logic [W:0]     shifted, trial;

    always_comb begin
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        rem_d    = rem_q;
        quot_d   = quot_q;
        dvsr_d   = dvsr_q;
        // quot_q doubles as the dividend shift register feeding the remainder
        shifted  = {rem_q, quot_q[W-1]};
        trial    = shifted - {1'b0, dvsr_q};
        if (load_i) begin
            acc_d    = '0;
            mcand_d  = {{W{1'b0}}, mag_a_i};
            mplier_d = mag_b_i;
            rem_d    = '0;
            quot_d   = mag_a_i;
            dvsr_d   = mag_b_i;
        end else if (step_i) begin
            if (mplier_q[0]) begin
                acc_d = acc_q + mcand_q;
            end
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            if (!trial[W]) begin
                rem_d  = trial[W-1:0];
                quot_d = {quot_q[W-2:0], 1'b1};
            end else begin
                rem_d  = shifted[W-1:0];
                quot_d = {quot_q[W-2:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            rem_q    <= '0;
            quot_q   <= '0;
            dvsr_q   <= '0;
        end else begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            rem_q    <= rem_d;
            quot_q   <= quot_d;
            dvsr_q   <= dvsr_d;
        end
    end

    assign prod_nxt_o = acc_d;
    assign quot_nxt_o = quot_d;
    assign rem_nxt_o  = rem_d;

endmodule

// File: rtl/mul_div_unit.sv
// RV32M multiply/divide unit: FSM, iteration counter, special-case detection
// and sign correction around the magnitude datapath.
module mul_div_unit
    import mul_div_pkg::*;
#(
    parameter int unsigned DATA_WIDTH          = DEF_DATA_WIDTH,
    parameter int unsigned REG_FILE_ADDR_WIDTH = 5
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic                           flush,
    input  logic [2:0]                     funct3,
    input  logic [DATA_WIDTH-1:0]          op_a,
    input  logic [DATA_WIDTH-1:0]          op_b,
    input  logic [REG_FILE_ADDR_WIDTH-1:0] rd_in,
    output logic                           busy,
    output logic                           done,
    output logic [DATA_WIDTH-1:0]          result,
    output logic [REG_FILE_ADDR_WIDTH-1:0] rd_out
);

    localparam int unsigned W = DATA_WIDTH;
    localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(DATA_WIDTH - 1);

    state_e                         state_q, state_d;
    op_e                            op_q, op_d, op_in;
    logic                           neg_q, neg_d, neg_in;
    logic [CNT_WIDTH-1:0]           cnt_q, cnt_d;
    logic [REG_FILE_ADDR_WIDTH-1:0] rd_q, rd_d, rd_out_q, rd_out_d;
    logic [W-1:0]                   result_q, result_d;

    logic           sign_a, sign_b, div_zero, div_ovf, special, load, step;
    logic [W-1:0]   mag_a, mag_b, special_val, final_val;
    logic [2*W-1:0] prod_nxt, prod_s;
    logic [W-1:0]   quot_nxt, rem_nxt, quot_s, rem_s;

    assign op_in = op_e'(funct3);

    always_comb begin
        sign_a   = op_a[W-1] && !(op_in inside {OP_MULHU, OP_DIVU, OP_REMU});
        sign_b   = op_b[W-1] && (op_in inside {OP_MUL, OP_MULH, OP_DIV, OP_REM});
        mag_a    = sign_a ? -op_a : op_a;
        mag_b    = sign_b ? -op_b : op_b;
        // remainder follows the dividend; products and quotients follow the sign xor
        neg_in   = (op_in == OP_REM) ? sign_a : (sign_a ^ sign_b);
        div_zero = funct3[2] && (op_b == '0);
        div_ovf  = (op_in inside {OP_DIV, OP_REM}) &&
                   (op_a == {1'b1, {(W-1){1'b0}}}) && (op_b == '1);
        special  = div_zero || div_ovf;
        if (div_zero) begin
            special_val = funct3[1] ? op_a : '1;
        end else begin
            special_val = funct3[1] ? '0 : op_a;
        end
    end

    mul_div_datapath #(.W(W)) u_datapath (
        .clk        (clk),
        .rst        (rst),
        .load_i     (load),
        .step_i     (step),
        .mag_a_i    (mag_a),
        .mag_b_i    (mag_b),
        .prod_nxt_o (prod_nxt),
        .quot_nxt_o (quot_nxt),
        .rem_nxt_o  (rem_nxt)
    );

    always_comb begin
        prod_s = neg_q ? -prod_nxt : prod_nxt;
        quot_s = neg_q ? -quot_nxt : quot_nxt;
        rem_s  = neg_q ? -rem_nxt  : rem_nxt;
        case (op_q)
            OP_MUL:                        final_val = prod_s[W-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU:  final_val = prod_s[2*W-1:W];
            OP_DIV, OP_DIVU:               final_val = quot_s;
            default:                       final_val = rem_s;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        neg_d    = neg_q;
        cnt_d    = cnt_q;
        rd_d     = rd_q;
        rd_out_d = rd_out_q;
        result_d = result_q;
        load     = 1'b0;
        step     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (special) begin
                        state_d  = DONE;
                        result_d = special_val;
                        rd_out_d = rd_in;
                    end else begin
                        state_d = CALC;
                        load    = 1'b1;
                        op_d    = op_in;
                        neg_d   = neg_in;
                        rd_d    = rd_in;
                        cnt_d   = '0;
                    end
                end
            end
            CALC: begin
                if (flush) begin
                    state_d = IDLE;
                end else begin
                    step  = 1'b1;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST) begin
                        state_d  = DONE;
                        result_d = final_val;
                        rd_out_d = rd_q;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            op_q     <= OP_MUL;
            neg_q    <= 1'b0;
            cnt_q    <= '0;
            rd_q     <= '0;
            rd_out_q <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            neg_q    <= neg_d;
            cnt_q    <= cnt_d;
            rd_q     <= rd_d;
            rd_out_q <= rd_out_d;
            result_q <= result_d;
        end
    end

    assign busy   = (state_q == CALC);
    assign done   = (state_q == DONE);
    assign result = result_q;
    assign rd_out = rd_out_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: vector table, random ops against a
// behavioural model, and hand-written flush/reset/back-to-back sequences.
module tb_mul_div_unit;
    import mul_div_pkg::*;

    localparam int W = 32;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        flush = 1'b0;
    logic [2:0]  funct3 = '0;
    logic [31:0] op_a = '0;
    logic [31:0] op_b = '0;
    logic [4:0]  rd_in = '0;
    logic        busy, done;
    logic [31:0] result;
    logic [4:0]  rd_out;

    always #5 clk = ~clk;

    mul_div_unit #(.DATA_WIDTH(32), .REG_FILE_ADDR_WIDTH(5)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .flush  (flush),
        .funct3 (funct3),
        .op_a   (op_a),
        .op_b   (op_b),
        .rd_in  (rd_in),
        .busy   (busy),
        .done   (done),
        .result (result),
        .rd_out (rd_out)
    );

    typedef struct {
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic [31:0] exp;
    } vec_t;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  rd;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    function automatic bit is_special(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        return f[2] && ((b == 32'd0) || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
    endfunction

    function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] sa, sbx, ua, ub, p;
        int          ia, ib;
        sa  = {{32{a[31]}}, a};
        sbx = {{32{b[31]}}, b};
        ua  = {32'd0, a};
        ub  = {32'd0, b};
        ia  = a;
        ib  = b;
        case (f)
            3'b000: begin p = sa * sbx; return p[31:0];  end
            3'b001: begin p = sa * sbx; return p[63:32]; end
            3'b010: begin p = sa * ub;  return p[63:32]; end
            3'b011: begin p = ua * ub;  return p[63:32]; end
            3'b100: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                return 32'(ia / ib);
            end
            3'b101: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'b110: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                return 32'(ia % ib);
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    // Scoreboard: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && done) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 result=%h expected no result", result);
            end else begin
                mon_e = sb.pop_front();
                check("result", result, mon_e.res);
                check("rd_out", 32'(rd_out), 32'(mon_e.rd));
            end
        end
    end

    task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input logic [31:0] exp);
        int lat, got, busy_cnt;
        sb.push_back('{res: exp, rd: rd});
        funct3 = f; op_a = a; op_b = b; rd_in = rd; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0; flush = 1'b0;
        lat = is_special(f, a, b) ? 1 : W + 1;
        got = 0;
        busy_cnt = 0;
        for (int i = 1; i <= W + 10; i++) begin
            @(negedge clk);
            if (busy) busy_cnt++;
            if (done) begin
                got = i;
                break;
            end
        end
        check("done_latency", 32'(got), 32'(lat));
        check("busy_cycles", 32'(busy_cnt), is_special(f, a, b) ? 32'd0 : 32'(W));
        @(negedge clk);
        check("done_single_pulse", 32'(done), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: got no end of test expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t vecs[19];
        logic [2:0]  rf;
        logic [31:0] ra, rb;
        int          dcnt, got;
        bit          acc2;

        vecs = '{
            '{OP_MUL,    32'h0000_0007, 32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB},
            '{OP_MULH,   32'h8000_0000, 32'h8000_0000, 5'd1,  32'h4000_0000},
            '{OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2,  32'hFFFF_FFFE},
            '{OP_MULHSU, 32'hFFFF_FFFF, 32'h0000_0002, 5'd3,  32'hFFFF_FFFF},
            '{OP_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd14, 32'h0000_0000},
            '{OP_DIV,    32'hFFFF_FFF9, 32'h0000_0002, 5'd4,  32'hFFFF_FFFD},
            '{OP_REM,    32'hFFFF_FFF9, 32'h0000_0002, 5'd6,  32'hFFFF_FFFF},
            '{OP_DIVU,   32'd100,       32'd7,         5'd7,  32'd14},
            '{OP_REMU,   32'd100,       32'd7,         5'd8,  32'd2},
            '{OP_DIV,    32'hFFFF_FF9C, 32'd7,         5'd15, 32'hFFFF_FFF2},
            '{OP_REM,    32'hFFFF_FF9C, 32'd7,         5'd16, 32'hFFFF_FFFE},
            '{OP_DIVU,   32'd5,         32'd0,         5'd9,  32'hFFFF_FFFF},
            '{OP_REM,    32'd5,         32'd0,         5'd10, 32'd5},
            '{OP_DIV,    32'd7,         32'd0,         5'd17, 32'hFFFF_FFFF},
            '{OP_REMU,   32'd7,         32'd0,         5'd13, 32'd7},
            '{OP_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 32'h8000_0000},
            '{OP_REM,    32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 32'd0},
            '{OP_MUL,    32'd0,         32'h1234_5678, 5'd0,  32'd0},
            '{OP_DIVU,   32'hFFFF_FFFF, 32'd1,         5'd31, 32'hFFFF_FFFF}
        };

        repeat (2) @(negedge clk);
        check("reset_busy",   32'(busy),   32'd0);
        check("reset_done",   32'(done),   32'd0);
        check("reset_result", result,      32'd0);
        check("reset_rd_out", 32'(rd_out), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        foreach (vecs[i]) run_op(vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].rd, vecs[i].exp);

        for (int i = 0; i < 10; i++) begin
            rf = 3'($urandom_range(0, 7));
            ra = $urandom;
            rb = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
            if (i == 9) begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
            run_op(rf, ra, rb, 5'(i + 18), model(rf, ra, rb));
        end

        // DIV aborted by flush in CALC cycle 10; a start seen during CALC is ignored.
        funct3 = OP_DIV; op_a = 32'd1000; op_b = 32'd7; rd_in = 5'd20; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(negedge clk);
        funct3 = OP_MUL; op_a = 32'd3; op_b = 32'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("start_in_calc_busy", 32'(busy), 32'd1);
        repeat (5) @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        check("flush_busy", 32'(busy), 32'd0);
        check("flush_done", 32'(done), 32'd0);
        dcnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) dcnt++;
        end
        check("flush_no_done", 32'(dcnt), 32'd0);

        flush = 1'b1;
        run_op(OP_DIVU, 32'd100, 32'd7, 5'd12, 32'd14);

        // Asynchronous reset between edges in the middle of CALC.
        funct3 = OP_MUL; op_a = 32'd7; op_b = 32'hFFFF_FFFD; rd_in = 5'd9; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (5) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrst_busy",   32'(busy),   32'd0);
        check("midrst_done",   32'(done),   32'd0);
        check("midrst_result", result,      32'd0);
        check("midrst_rd_out", 32'(rd_out), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Back-to-back with start held high across the first op's completion.
        sb.push_back('{res: 32'hFFFF_FFEB, rd: 5'd5});
        funct3 = OP_MUL; op_a = 32'd7; op_b = 32'hFFFF_FFFD; rd_in = 5'd5; start = 1'b1;
        @(posedge clk);
        #1;
        sb.push_back('{res: 32'd3, rd: 5'd6});
        funct3 = OP_DIVU; op_a = 32'd9; op_b = 32'd3; rd_in = 5'd6;
        dcnt = 0;
        acc2 = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            if (done) dcnt++;
            else if (dcnt > 0 && busy) begin
                start = 1'b0;
                acc2 = 1'b1;
                break;
            end
        end
        start = 1'b0;
        check("b2b_second_accepted", 32'(acc2), 32'd1);
        check("b2b_first_done_width", 32'(dcnt), 32'd1);
        got = 0;
        for (int i = 0; i < W + 10; i++) begin
            @(negedge clk);
            if (done) begin
                got = 1;
                break;
            end
        end
        check("b2b_second_done", 32'(got), 32'd1);
        @(negedge clk);
        check("b2b_second_done_width", 32'(done), 32'd0);

        repeat (3) @(negedge clk);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
